// File: rtl/rx_capture_buffer.sv
// Circular capture buffer for rx front-end samples: records continuously once armed,
// stops POST_TRIG samples after a trigger, then streams the window oldest-first.
module rx_capture_buffer #(
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned POST_TRIG = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              trigger,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              drop
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_TRIG);

    typedef enum logic [1:0] {IDLE, FILL, POST, DRAIN} state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt, rd_ptr;
    logic [CNT_W-1:0]  fill_cnt, fill_nxt, post_cnt, rd_left;

    logic              pipe_v, pipe_last;
    logic              skid_v, skid_last;
    logic [DATA_W-1:0] skid_data;

    logic              wr_en_c, pop_c, issue_c, done_c;
    logic [1:0]        occ_c;

    // Next-state decode; abort overrides everything
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (arm) next_state = FILL;
                FILL:    if (trigger)
                             next_state = (in_valid && POST_C == CNT_W'(1)) ? DRAIN : POST;
                POST:    if (in_valid && (post_cnt + CNT_W'(1)) == POST_C) next_state = DRAIN;
                DRAIN:   if (pop_c && out_last) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Write pointer/fill bookkeeping and readout flow control
    always_comb begin
        wr_en_c    = in_valid && !abort && (state == FILL || state == POST);
        wr_ptr_nxt = wr_ptr;
        fill_nxt   = fill_cnt;
        if (wr_en_c) begin
            wr_ptr_nxt = wr_ptr + ADDR_W'(1);
            if (fill_cnt != DEPTH_C) fill_nxt = fill_cnt + CNT_W'(1);
        end
        pop_c   = (state == DRAIN) && !abort && out_valid && out_ready;
        // Beats held or in flight after this cycle's pop; the output + skid pair holds two
        occ_c   = 2'(out_valid) + 2'(skid_v) + 2'(pipe_v) - 2'(pop_c);
        issue_c = (state == DRAIN) && !abort && (rd_left != '0) && (occ_c < 2'd2);
        done_c  = pop_c && out_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            post_cnt <= '0;
            rd_ptr   <= '0;
            rd_left  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= done_c;

            if (state == IDLE && arm && !abort) begin
                wr_ptr   <= '0;
                fill_cnt <= '0;
                post_cnt <= '0;
                drop     <= 1'b0;
            end else begin
                wr_ptr   <= wr_ptr_nxt;
                fill_cnt <= fill_nxt;
            end

            if (state == FILL && trigger && !abort)
                post_cnt <= CNT_W'(in_valid);
            else if (state == POST && wr_en_c)
                post_cnt <= post_cnt + CNT_W'(1);

            if (state == DRAIN && in_valid) drop <= 1'b1;

            // Window start is computed from the pointers as they stand after the final write
            if (state != DRAIN && next_state == DRAIN) begin
                rd_ptr  <= wr_ptr_nxt - fill_nxt[ADDR_W-1:0];
                rd_left <= fill_nxt;
            end else if (issue_c) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                rd_left <= rd_left - CNT_W'(1);
            end
        end
    end

    // Simple dual-port RAM, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr] <= in_data;
        if (issue_c) ram_q <= mem[rd_ptr];
    end

    // Read pipe -> skid -> output register; keeps 1 beat/cycle across stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v    <= 1'b0;
            pipe_last <= 1'b0;
            skid_v    <= 1'b0;
            skid_last <= 1'b0;
            skid_data <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (abort || state != DRAIN) begin
            pipe_v    <= 1'b0;
            skid_v    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            pipe_v    <= issue_c;
            pipe_last <= (rd_left == CNT_W'(1));
            if (pop_c || !out_valid) begin
                if (skid_v) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    out_last  <= skid_last;
                    skid_v    <= pipe_v;
                    skid_data <= ram_q;
                    skid_last <= pipe_last;
                end else if (pipe_v) begin
                    out_valid <= 1'b1;
                    out_data  <= ram_q;
                    out_last  <= pipe_last;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else if (pipe_v) begin
                skid_v    <= 1'b1;
                skid_data <= ram_q;
                skid_last <= pipe_last;
            end
        end
    end

endmodule

// File: tb/tb_rx_capture_buffer.sv
// Scoreboard bench for rx_capture_buffer: the reference window is the last
// min(DEPTH, n) samples of each capture; a negedge monitor checks every handshake.
module tb_rx_capture_buffer;

    localparam int unsigned DATA_W    = 18;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned POST_TRIG = 4;
    localparam int          DEPTH     = 16;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arm = 1'b0, trigger = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid, out_last, busy, done, drop;
    logic [DATA_W-1:0] out_data;

    int    total = 0, bad = 0;
    int    beats_acc = 0, done_cnt = 0, rmode = 0, pidx = 0;
    beat_t exp_q[$];
    bit    pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic              prev_v = 1'b0, prev_r = 1'b0, prev_a = 1'b0, prev_l = 1'b0;
    logic [DATA_W-1:0] prev_d = '0;
    bit                exp_done = 1'b0;

    rx_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .POST_TRIG(POST_TRIG)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trigger(trigger), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want completion", name);
    endtask

    // Downstream ready: always, fixed 1,0,0,1,0,1 pattern, or random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = pat[pidx]; pidx = (pidx + 1) % 6; end
                default: out_ready = 1'($urandom % 2);
            endcase
        end
    end

    // Monitor: handshakes happen at the next posedge, so sample at negedge
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v   = 1'b0;
                exp_done = 1'b0;
            end else begin
                if (exp_done) begin
                    check("done_pulse", 32'(done), 1);
                    check("valid_after_last", 32'(out_valid), 0);
                    check("busy_after_last", 32'(busy), 0);
                    done_cnt++;
                    exp_done = 1'b0;
                end else begin
                    check("done_idle", 32'(done), 0);
                end
                if (prev_v && !prev_r && !prev_a) begin
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_data", 32'(out_data), 32'(prev_d));
                    check("stall_last", 32'(out_last), 32'(prev_l));
                end
                if (out_valid && out_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(out_data), 32'(e.d));
                        check("beat_last", 32'(out_last), 32'(e.l));
                        beats_acc++;
                        if (e.l) exp_done = 1'b1;
                    end
                end
                prev_v = out_valid;
                prev_r = out_ready;
                prev_a = abort;
                prev_d = out_data;
                prev_l = out_last;
            end
        end
    end

    // Arm, feed samples base+1..base+n (trigger on sample trig_idx), queue the expected window
    task automatic send_capture(input int trig_idx, input int base, input int gap_max, input bit junk);
        int n, first, gaps;
        n = trig_idx + int'(POST_TRIG) - 1;
        @(posedge clk);
        #1;
        arm      = 1'b1;
        trigger  = 1'($urandom % 2);
        in_valid = 1'($urandom % 2);
        in_data  = 18'($urandom);
        @(posedge clk);
        #1;
        arm = 1'b0; trigger = 1'b0; in_valid = 1'b0;
        check("busy_after_arm", 32'(busy), 1);
        check("drop_after_arm", 32'(drop), 0);
        for (int i = 1; i <= n; i++) begin
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = 18'($urandom);
                trigger  = (i > trig_idx) ? 1'($urandom % 2) : 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = DATA_W'(base + i);
            trigger  = (i == trig_idx);
            @(posedge clk);
            #1;
        end
        in_valid = junk;
        in_data  = 18'd99;
        trigger  = 1'b0;
        first = (n > DEPTH) ? n - DEPTH + 1 : 1;
        for (int i = first; i <= n; i++)
            exp_q.push_back('{d: DATA_W'(base + i), l: (i == n)});
    endtask

    task automatic wait_done(input string name);
        int  start;
        bit  ok;
        start = done_cnt;
        ok    = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (done_cnt > start) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            fail({name, "_timeout"});
            exp_q.delete();
        end
        check({name, "_left"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int b0;
        bit ab_ok, junk;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_drop", 32'(drop), 0);
        rst_n = 1'b1;

        // trigger and samples are ignored in IDLE
        in_valid = 1'b1; trigger = 1'b1; in_data = 18'd5;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0; trigger = 1'b0;
        check("idle_busy", 32'(busy), 0);
        check("idle_valid", 32'(out_valid), 0);

        rmode = 0;
        send_capture(7, 0, 0, 1'b0);
        wait_done("basic");

        send_capture(37, 0, 0, 1'b0);
        wait_done("wrap");

        rmode = 1; pidx = 0;
        send_capture(7, 0, 0, 1'b0);
        wait_done("stall");

        rmode = 0;
        send_capture(7, 0, 0, 1'b1);
        wait_done("drop");
        check("drop_set", 32'(drop), 1);

        // abort after three accepted beats
        send_capture(7, 0, 0, 1'b0);
        b0 = beats_acc;
        ab_ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (beats_acc - b0 >= 3) begin
                ab_ok = 1'b1;
                break;
            end
        end
        if (!ab_ok) fail("abort_wait");
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(out_valid), 0);
        check("abort_busy", 32'(busy), 0);
        exp_q.delete();
        send_capture(1, 4, 0, 1'b0);
        wait_done("after_abort");

        // async reset in the middle of POST
        @(posedge clk);
        #1;
        arm = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            trigger  = (i == 3);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; trigger = 1'b0;
        check("post_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_last", 32'(out_last), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_drop", 32'(drop), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_capture(1, 0, 0, 1'b0);
        wait_done("after_reset");

        // randomized captures: trigger point, gaps, ready behaviour, junk in DRAIN
        for (int k = 0; k < 12; k++) begin
            rmode = int'($urandom % 3);
            junk  = 1'($urandom % 2);
            send_capture(int'($urandom_range(40, 1)), int'($urandom_range(1000, 0)) * 64,
                         int'($urandom_range(2, 0)), junk);
            wait_done("random");
            if (junk) check("random_drop", 32'(drop), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_capture_buffer.md
Name: rx_capture_buffer

Overview:
- Parametrised successor to the rx sample BRAM: a circular capture buffer for rx front-end samples.
- Once armed, it continuously records incoming samples into an inferred simple dual-port RAM (one clock).
- On trigger, it records a fixed number of post-trigger samples, then streams the captured window oldest-to-newest over a valid/ready interface.
- Sits between the rx sample path and the correlator/readout logic.

Parameters:
- DATA_W, 18, sample width in bits.
- ADDR_W, 9, address width; DEPTH = 2**ADDR_W entries.
- POST_TRIG, 256, samples written from the trigger sample onward; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  start a capture (honoured in IDLE only).
- trigger  in  1  trigger event (honoured in FILL only).
- abort  in  1  synchronous abort; returns to IDLE from any state.
- in_valid  in  1  sample strobe.
- in_data  in  DATA_W  sample.
- out_valid  out  1  readout beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DATA_W  readout sample.
- out_last  out  1  final beat of the window.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final beat handshake.
- drop  out  1  sticky: in_valid seen while in DRAIN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wr_ptr=0, fill_cnt=0, post_cnt=0.
  - All outputs 0.
  - RAM contents are not reset.
- States: IDLE, FILL, POST, DRAIN.
- IDLE:
  - in_valid and trigger are ignored.
  - arm=1 -> FILL next cycle; clears wr_ptr, fill_cnt, drop.
  - arm and trigger asserted together: arm only.
- FILL:
  - Each in_valid writes ram[wr_ptr]=in_data.
  - wr_ptr increments mod DEPTH.
  - fill_cnt (ADDR_W+1 bits) increments, saturating at DEPTH.
  - trigger=1 -> POST. A sample with in_valid in the trigger cycle is the first post-trigger sample (post_cnt=1).
- POST:
  - Writes continue as in FILL; post_cnt increments per write.
  - When post_cnt reaches POST_TRIG on a write -> DRAIN next cycle.
  - POST_TRIG=1 with in_valid in the trigger cycle: go FILL -> DRAIN directly.
  - trigger is ignored here.
- DRAIN:
  - No RAM writes. in_valid sets drop=1 (sticky until next arm).
  - Readout: N = fill_cnt beats, starting at rd_ptr = (wr_ptr - fill_cnt) mod DEPTH, incrementing mod DEPTH.
  - RAM read latency is 1 cycle; a prefetch/skid register presents data.
  - First out_valid appears no earlier than 2 cycles and no later than 3 cycles after entering DRAIN.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
  - out_valid, once high, stays high until handshake. out_data and out_last are stable while out_valid=1 and out_ready=0.
  - out_last=1 only on beat N.
  - After the beat-N handshake: out_valid=0, done=1 for one cycle, state=IDLE.
- Wrap-around: with more than DEPTH writes, the oldest samples are overwritten; the window is the last DEPTH samples.
- abort=1 (any state): next cycle state=IDLE, out_valid=0, out_last=0, done=0. drop is kept. abort has priority over arm, trigger and handshake.
- Async reset mid-operation: immediate return to the reset values above.
- busy=1 in FILL, POST and DRAIN.

Test Plan:
- DATA_W=18, ADDR_W=4, POST_TRIG=4 for all scenarios.
- arm; samples 1..10 with in_valid=1; trigger with sample 7 -> DRAIN after sample 10; outputs 1..10, out_last on 10, done pulse, busy=0.
- arm; samples 1..40; trigger with sample 37 -> exactly 16 beats 25..40, out_last on 40 (wrap check).
- Scenario 1 with out_ready pattern 1,0,0,1,0,1… -> same sequence 1..10; out_data held while stalled; no duplicates or losses.
- in_valid=1 with data 99 during DRAIN -> drop=1, output still 1..10; next arm -> drop=0.
- abort after 3 accepted beats -> out_valid=0 next cycle, busy=0; re-arm and capture 5..8 with trigger on 5 -> outputs 5..8.
- rst_n low mid-POST -> all outputs 0 immediately. After release, arm plus samples 1..4 with trigger on 1 -> outputs 1..4.
